// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and data access, one transaction at a time.
// Data side has priority; a starvation counter periodically forces a fetch grant.
module mem_arbiter #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            if_req_i,
  input  logic [XLEN-1:0] if_adr_i,
  output logic            if_rvalid_o,
  output logic [31:0]     if_rdata_o,
  input  logic            flush_i,
  input  logic            d_req_i,
  input  logic [XLEN-1:0] d_adr_i,
  input  logic            d_we_i,
  input  logic [XLEN-1:0] d_wdata_i,
  input  logic [2:0]      d_size_i,
  output logic            d_rvalid_o,
  output logic [XLEN-1:0] d_rdata_o,
  output logic            mem_req_o,
  output logic [XLEN-1:0] mem_adr_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_wdata_o,
  output logic [2:0]      mem_size_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            busy_o
);

  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_MAX);

  typedef enum logic [1:0] {StIdle, StReq, StRsp} state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;     // 1 = fetch owns the transaction
  logic              discard_q, discard_d;
  logic [CntW-1:0]   starve_q, starve_d;
  logic [XLEN-1:0]   adr_q, adr_d;
  logic              we_q, we_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [2:0]        size_q, size_d;

  logic fetch_seen, fetch_wins, rsp_done;

  // A flush in the arbitration cycle hides the fetch request for that cycle.
  assign fetch_seen = if_req_i && !flush_i;
  assign fetch_wins = fetch_seen && (!d_req_i || (starve_q == StarveMax));
  assign rsp_done   = (state_q == StRsp) && mem_rvalid_i;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q   <= 1'b0;
      discard_q <= 1'b0;
      starve_q  <= '0;
      adr_q     <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      size_q    <= 3'b000;
    end else begin
      owner_q   <= owner_d;
      discard_q <= discard_d;
      starve_q  <= starve_d;
      adr_q     <= adr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      size_q    <= size_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    discard_d = discard_q;
    starve_d  = starve_q;
    adr_d     = adr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    size_d    = size_q;
    unique case (state_q)
      StIdle: begin
        if (fetch_wins) begin
          state_d  = StReq;
          owner_d  = 1'b1;
          adr_d    = if_adr_i;
          we_d     = 1'b0;
          wdata_d  = '0;
          size_d   = 3'b010;
          starve_d = '0;
        end else if (d_req_i) begin
          state_d = StReq;
          owner_d = 1'b0;
          adr_d   = d_adr_i;
          we_d    = d_we_i;
          wdata_d = d_wdata_i;
          size_d  = d_size_i;
          if (fetch_seen && (starve_q != StarveMax)) begin
            starve_d = starve_q + 1'b1;
          end
        end
      end
      StReq: begin
        if (flush_i && owner_q) discard_d = 1'b1;
        if (mem_gnt_i) state_d = StRsp;
      end
      StRsp: begin
        if (mem_rvalid_i) begin
          state_d   = StIdle;
          discard_d = 1'b0;
        end else if (flush_i && owner_q) begin
          discard_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_req_o   = (state_q == StReq);
    mem_adr_o   = adr_q;
    mem_we_o    = we_q;
    mem_wdata_o = wdata_q;
    mem_size_o  = size_q;
    busy_o      = (state_q != StIdle);
    if_rvalid_o = rsp_done && owner_q && !discard_q && !flush_i;
    d_rvalid_o  = rsp_done && !owner_q;
    if_rdata_o  = if_rvalid_o ? mem_rdata_i[31:0] : 32'h0;
    d_rdata_o   = d_rvalid_o ? mem_rdata_i : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch/data arbitration, starvation, flush, wait states, reset.
module tb_mem_arbiter;

  logic        clk;
  logic        reset_n;
  logic        if_req_i;
  logic [31:0] if_adr_i;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        flush_i;
  logic        d_req_i;
  logic [31:0] d_adr_i;
  logic        d_we_i;
  logic [31:0] d_wdata_i;
  logic [2:0]  d_size_i;
  logic        d_rvalid_o;
  logic [31:0] d_rdata_o;
  logic        mem_req_o;
  logic [31:0] mem_adr_o;
  logic        mem_we_o;
  logic [31:0] mem_wdata_o;
  logic [2:0]  mem_size_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        busy_o;

  int errors = 0;
  int checks = 0;

  mem_arbiter #(.XLEN(32), .STARVE_MAX(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .if_req_i     (if_req_i),
    .if_adr_i     (if_adr_i),
    .if_rvalid_o  (if_rvalid_o),
    .if_rdata_o   (if_rdata_o),
    .flush_i      (flush_i),
    .d_req_i      (d_req_i),
    .d_adr_i      (d_adr_i),
    .d_we_i       (d_we_i),
    .d_wdata_i    (d_wdata_i),
    .d_size_i     (d_size_i),
    .d_rvalid_o   (d_rvalid_o),
    .d_rdata_o    (d_rdata_o),
    .mem_req_o    (mem_req_o),
    .mem_adr_o    (mem_adr_o),
    .mem_we_o     (mem_we_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_size_o   (mem_size_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .busy_o       (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Grant order for two continuous requesters with STARVE_MAX=4 (1 = fetch).
  logic exp_fetch [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    reset_n = 1'b0;
    if_req_i = 1'b0; if_adr_i = '0; flush_i = 1'b0;
    d_req_i = 1'b0; d_adr_i = '0; d_we_i = 1'b0; d_wdata_i = '0; d_size_i = 3'b000;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    #2;
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_mem_req", 32'(mem_req_o), 32'h0);
    chk("rst_mem_adr", mem_adr_o, 32'h0);
    chk("rst_if_rvalid", 32'(if_rvalid_o), 32'h0);
    chk("rst_d_rvalid", 32'(d_rvalid_o), 32'h0);
    tick; tick;
    reset_n = 1'b1;

    // Fetch only, zero wait states
    if_req_i = 1'b1; if_adr_i = 32'h80;
    #2 chk("t1_idle_req", 32'(mem_req_o), 32'h0);
    tick;
    chk("t1_mem_req", 32'(mem_req_o), 32'h1);
    chk("t1_mem_adr", mem_adr_o, 32'h80);
    chk("t1_mem_we", 32'(mem_we_o), 32'h0);
    chk("t1_mem_size", 32'(mem_size_o), 32'h2);
    mem_gnt_i = 1'b1;
    tick;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h13;
    #2;
    chk("t1_mem_req_rsp", 32'(mem_req_o), 32'h0);
    chk("t1_if_rvalid", 32'(if_rvalid_o), 32'h1);
    chk("t1_if_rdata", if_rdata_o, 32'h13);
    chk("t1_d_rvalid", 32'(d_rvalid_o), 32'h0);
    chk("t1_d_rdata", d_rdata_o, 32'h0);
    tick;
    mem_rvalid_i = 1'b0; if_req_i = 1'b0;

    // Stray response and grant in IDLE are ignored
    mem_rvalid_i = 1'b1; mem_gnt_i = 1'b1;
    #2 chk("stray_if_rvalid", 32'(if_rvalid_o), 32'h0);
    chk("stray_d_rvalid", 32'(d_rvalid_o), 32'h0);
    tick;
    mem_rvalid_i = 1'b0; mem_gnt_i = 1'b0;
    chk("stray_busy", 32'(busy_o), 32'h0);

    // Store and fetch together: store first
    d_req_i = 1'b1; d_adr_i = 32'h1000; d_we_i = 1'b1; d_wdata_i = 32'hDEADBEEF; d_size_i = 3'b010;
    if_req_i = 1'b1; if_adr_i = 32'h84;
    tick;
    chk("t2_adr_d", mem_adr_o, 32'h1000);
    chk("t2_we_d", 32'(mem_we_o), 32'h1);
    chk("t2_wdata_d", mem_wdata_o, 32'hDEADBEEF);
    chk("t2_size_d", 32'(mem_size_o), 32'h2);
    mem_gnt_i = 1'b1;
    tick;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0;
    #2 chk("t2_d_rvalid", 32'(d_rvalid_o), 32'h1);
    chk("t2_if_rvalid_d", 32'(if_rvalid_o), 32'h0);
    tick;
    mem_rvalid_i = 1'b0; d_req_i = 1'b0; d_we_i = 1'b0;
    tick;
    chk("t2_adr_i", mem_adr_o, 32'h84);
    chk("t2_we_i", 32'(mem_we_o), 32'h0);
    chk("t2_wdata_i", mem_wdata_o, 32'h0);
    mem_gnt_i = 1'b1;
    tick;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h00000093;
    #2 chk("t2_if_rvalid", 32'(if_rvalid_o), 32'h1);
    chk("t2_if_rdata", if_rdata_o, 32'h93);
    tick;
    mem_rvalid_i = 1'b0; if_req_i = 1'b0;

    // Starvation: both requesting continuously
    d_req_i = 1'b1; d_adr_i = 32'h4000; d_we_i = 1'b1; d_wdata_i = 32'h1;
    if_req_i = 1'b1; if_adr_i = 32'h300;
    for (int i = 0; i < 10; i++) begin
      tick;
      chk($sformatf("t3_adr_%0d", i), mem_adr_o, exp_fetch[i] ? 32'h300 : 32'h4000);
      chk($sformatf("t3_we_%0d", i), 32'(mem_we_o), exp_fetch[i] ? 32'h0 : 32'h1);
      if (exp_fetch[i]) chk($sformatf("t3_starve_%0d", i), 32'(dut.starve_q), 32'h0);
      mem_gnt_i = 1'b1;
      tick;
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
      #2 chk($sformatf("t3_ifv_%0d", i), 32'(if_rvalid_o), 32'(exp_fetch[i]));
      chk($sformatf("t3_dv_%0d", i), 32'(d_rvalid_o), 32'(!exp_fetch[i]));
      tick;
      mem_rvalid_i = 1'b0;
    end
    d_req_i = 1'b0; d_we_i = 1'b0; if_req_i = 1'b0;
    tick;

    // Flush in IDLE masks the fetch for that cycle; flush in RSP discards the response
    if_req_i = 1'b1; if_adr_i = 32'h180; flush_i = 1'b1;
    tick;
    flush_i = 1'b0;
    chk("t4_flush_idle_busy", 32'(busy_o), 32'h0);
    tick;
    chk("t4_adr_flushed", mem_adr_o, 32'h180);
    mem_gnt_i = 1'b1;
    tick;
    mem_gnt_i = 1'b0; flush_i = 1'b1;
    tick;
    flush_i = 1'b0; if_adr_i = 32'h200; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h77;
    #2 chk("t4_discard_rvalid", 32'(if_rvalid_o), 32'h0);
    chk("t4_discard_rdata", if_rdata_o, 32'h0);
    tick;
    mem_rvalid_i = 1'b0;
    chk("t4_idle_after", 32'(busy_o), 32'h0);
    tick;
    chk("t4_adr_200", mem_adr_o, 32'h200);
    mem_gnt_i = 1'b1;
    tick;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h55;
    #2 chk("t4_if_rvalid", 32'(if_rvalid_o), 32'h1);
    chk("t4_if_rdata", if_rdata_o, 32'h55);
    tick;
    mem_rvalid_i = 1'b0; if_req_i = 1'b0;

    // Load with 3 wait states; flush during it has no effect on data
    d_req_i = 1'b1; d_adr_i = 32'h2000; d_we_i = 1'b0; d_size_i = 3'b000;
    tick;
    for (int w = 0; w < 3; w++) begin
      chk($sformatf("t5_req_%0d", w), 32'(mem_req_o), 32'h1);
      chk($sformatf("t5_adr_%0d", w), mem_adr_o, 32'h2000);
      chk($sformatf("t5_size_%0d", w), 32'(mem_size_o), 32'h0);
      flush_i = (w == 1);
      tick;
    end
    flush_i = 1'b0; mem_gnt_i = 1'b1;
    #2 chk("t5_req_gnt", 32'(mem_req_o), 32'h1);
    tick;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000CAFE; flush_i = 1'b1;
    #2 chk("t5_d_rvalid", 32'(d_rvalid_o), 32'h1);
    chk("t5_d_rdata", d_rdata_o, 32'h0000CAFE);
    chk("t5_if_rdata", if_rdata_o, 32'h0);
    tick;
    mem_rvalid_i = 1'b0; flush_i = 1'b0; d_req_i = 1'b0;

    // Reset during RSP, then a stray response after release
    d_req_i = 1'b1; d_adr_i = 32'h3000; d_we_i = 1'b1; d_wdata_i = 32'h5A;
    tick;
    mem_gnt_i = 1'b1;
    tick;
    mem_gnt_i = 1'b0; d_req_i = 1'b0; d_we_i = 1'b0;
    #1 chk("t6_busy_pre", 32'(busy_o), 32'h1);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(busy_o), 32'h0);
    chk("t6_rst_adr", mem_adr_o, 32'h0);
    chk("t6_rst_we", 32'(mem_we_o), 32'h0);
    chk("t6_rst_wdata", mem_wdata_o, 32'h0);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234;
    #1 chk("t6_rst_d_rvalid", 32'(d_rvalid_o), 32'h0);
    tick;
    reset_n = 1'b1;
    #2 chk("t6_stray_d_rvalid", 32'(d_rvalid_o), 32'h0);
    chk("t6_stray_if_rvalid", 32'(if_rvalid_o), 32'h0);
    chk("t6_stray_d_rdata", d_rdata_o, 32'h0);
    tick;
    mem_rvalid_i = 1'b0;
    chk("t6_busy_post", 32'(busy_o), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
